// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and helpers shared by the multiply/divide unit.
package mdu_pkg;
   localparam logic [2:0] MDU_OP_NONE  = 3'd0;
   localparam logic [2:0] MDU_OP_MULT  = 3'd1;
   localparam logic [2:0] MDU_OP_MULTU = 3'd2;
   localparam logic [2:0] MDU_OP_DIV   = 3'd3;
   localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
   localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
   localparam logic [2:0] MDU_OP_MTLO  = 3'd6;
   localparam logic [1:0] MDU_IDLE = 2'd0;
   localparam logic [1:0] MDU_MUL  = 2'd1;
   localparam logic [1:0] MDU_DIV  = 2'd2;
   localparam logic [1:0] MDU_DONE = 2'd3;
   localparam int MDU_ITER = 32;
   function automatic logic [31:0] condNeg(input logic [31:0] x, input logic n);
      return n ? 32'd0 - x : x;
   endfunction
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: radix-2 restoring divider on magnitudes, one quotient bit per step.
module mdu_div_core (
   input  logic        clk,
   input  logic        start,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quoNext,
   output logic [31:0] remNext
);
   logic [31:0] quo, rem, dsr;
   logic [32:0] trial;
   // a zero divisor never borrows, so it yields all-ones quotient and remainder = dividend
   assign trial   = {rem, quo[31]} - {1'b0, dsr};
   assign quoNext = {quo[30:0], ~trial[32]};
   assign remNext = trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
   always_ff @(posedge clk) begin
      if (start) begin
         quo <= dividend;
         rem <= '0;
         dsr <= divisor;
      end else if (step) begin
         quo <= quoNext;
         rem <= remNext;
      end
   end
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: iterative multiply/divide unit owning HI/LO with EX-stage ready handshake.
// Defining MDU_FAST_MUL_EN replaces the 32-cycle multiply with a single-cycle one.
module mdu_unit
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic [2:0]  MDUOpE,
   input  logic [31:0] SrcAE,
   input  logic [31:0] SrcBE,
   input  logic        MemStall,
   input  logic        ExceptDealM,
   output logic        MDUReadyE,
   output logic [31:0] HIOut,
   output logic [31:0] LOOut
);
   logic [1:0]  state;
   logic [4:0]  cnt;
   logic [31:0] magA, absA, absB, quoNext, remNext, res_hi, res_lo, finHi, finLo;
   logic [63:0] acc, accNext, prod;
   logic [32:0] sum;
   logic        negRes, negRem, isSigned, isMul, isDiv, startMul, signA, signB, busy, commitOk, lastIter;
   assign isSigned = MDUOpE == MDU_OP_MULT || MDUOpE == MDU_OP_DIV;
   assign isMul    = MDUOpE == MDU_OP_MULT || MDUOpE == MDU_OP_MULTU;
   assign isDiv    = MDUOpE == MDU_OP_DIV || MDUOpE == MDU_OP_DIVU;
   assign signA    = isSigned && SrcAE[31];
   assign signB    = isSigned && SrcBE[31];
   assign absA     = condNeg(SrcAE, signA);
   assign absB     = condNeg(SrcBE, signB);
   assign commitOk = !MemStall && !ExceptDealM;
   assign lastIter = cnt == 5'(MDU_ITER - 1);
`ifdef MDU_FAST_MUL_EN
   logic [63:0] fastMag, fastProd;
   assign startMul = 1'b0;
   assign fastMag  = {32'd0, absA} * {32'd0, absB};
   assign fastProd = (signA ^ signB) ? 64'd0 - fastMag : fastMag;
`else
   assign startMul = isMul;
`endif
   // shift-add: low half starts as the multiplier and is consumed from bit 0
   assign sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, magA} : 33'd0);
   assign accNext = {sum, acc[31:1]};
   assign prod    = negRes ? 64'd0 - accNext : accNext;
   assign finHi   = state == MDU_MUL ? prod[63:32] : condNeg(remNext, negRem);
   assign finLo   = state == MDU_MUL ? prod[31:0] : condNeg(quoNext, negRes);
   // ready depends on op and state only, keeping the hazard-unit path loop-free
   assign busy      = (state == MDU_IDLE && (startMul || isDiv)) || state == MDU_MUL || state == MDU_DIV;
   assign MDUReadyE = !resetn || !busy;
   mdu_div_core divCore (
      .clk     (clk),
      .start   (state == MDU_IDLE && isDiv),
      .step    (state == MDU_DIV),
      .dividend(absA),
      .divisor (absB),
      .quoNext (quoNext),
      .remNext (remNext)
   );
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= MDU_IDLE;
         cnt   <= '0;
         HIOut <= '0;
         LOOut <= '0;
      end else if (state == MDU_IDLE) begin
         // a flushed EX op must not start, or it would commit later
         if (!ExceptDealM && (startMul || isDiv)) begin
            state  <= startMul ? MDU_MUL : MDU_DIV;
            cnt    <= '0;
            magA   <= absA;
            acc    <= {32'd0, absB};
            negRes <= signA ^ signB;
            negRem <= signA;
         end else if (commitOk) begin
            if (MDUOpE == MDU_OP_MTHI) HIOut <= SrcAE;
            if (MDUOpE == MDU_OP_MTLO) LOOut <= SrcAE;
`ifdef MDU_FAST_MUL_EN
            if (isMul) begin
               HIOut <= fastProd[63:32];
               LOOut <= fastProd[31:0];
            end
`endif
         end
      end else if (ExceptDealM) begin
         state <= MDU_IDLE;
      end else if (state == MDU_DONE) begin
         if (!MemStall) begin
            HIOut <= res_hi;
            LOOut <= res_lo;
            state <= MDU_IDLE;
         end
      end else begin
         cnt <= cnt + 5'd1;
         acc <= accNext;
         if (lastIter) begin
            state  <= MDU_DONE;
            res_hi <= finHi;
            res_lo <= finLo;
         end
      end
   end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: scoreboard bench for mdu_unit; driver queues expected HI/LO, monitor checks at each retire.
module tb_mdu_unit;
   import mdu_pkg::*;
   logic        clk = 1'b0, resetn = 1'b0, MemStall = 1'b0, ExceptDealM = 1'b0, MDUReadyE;
   logic [2:0]  MDUOpE = MDU_OP_NONE;
   logic [31:0] SrcAE = '0, SrcBE = '0, HIOut, LOOut;
   logic [31:0] curHi = '0, curLo = '0, prevHi, prevLo;
   logic [63:0] sb[$];
   logic [63:0] expVal;
   logic        retireNext = 1'b0;
   int          checks = 0, failures = 0, low;
`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LOW = 0;
`else
   localparam int MUL_LOW = 33;
`endif
   always #5 clk = ~clk;
   mdu_unit dut (
      .clk        (clk),
      .resetn     (resetn),
      .MDUOpE     (MDUOpE),
      .SrcAE      (SrcAE),
      .SrcBE      (SrcBE),
      .MemStall   (MemStall),
      .ExceptDealM(ExceptDealM),
      .MDUReadyE  (MDUReadyE),
      .HIOut      (HIOut),
      .LOOut      (LOOut)
   );
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // an instruction retires when EX is ready, not frozen and not flushed
   always @(negedge clk) begin
      #2;
      retireNext = resetn && MDUReadyE && !MemStall && !ExceptDealM && MDUOpE != MDU_OP_NONE && MDUOpE != 3'd7;
   end
   always @(posedge clk) begin
      if (retireNext) begin
         #1;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected commit: got HI=%h LO=%h expected no commit", HIOut, LOOut);
         end else begin
            expVal = sb.pop_front();
            check("commit HI", HIOut, expVal[63:32]);
            check("commit LO", LOOut, expVal[31:0]);
         end
      end
   end
   task automatic waitReady();
      low = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (MDUReadyE) break;
         low++;
         @(negedge clk);
      end
   endtask
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int expLow, input string name);
      @(negedge clk);
      MDUOpE = op;
      SrcAE  = a;
      SrcBE  = b;
      sb.push_back({hi, lo});
      curHi = hi;
      curLo = lo;
      waitReady();
      check({name, " busy cycles"}, 32'(low), 32'(expLow));
      @(posedge clk);
      @(negedge clk);
      MDUOpE = MDU_OP_NONE;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      MDUOpE = MDU_OP_MULT;
      repeat (2) @(negedge clk);
      #1;
      check("reset ready", 32'(MDUReadyE), 32'd1);
      check("reset HI", HIOut, 32'd0);
      check("reset LO", LOOut, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      MDUOpE = MDU_OP_NONE;
      issue(MDU_OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LOW, "mult -2*3");
      issue(MDU_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LOW, "multu max");
      issue(MDU_OP_MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, MUL_LOW, "mult x*-1");
      issue(MDU_OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, "div -7/2");
      issue(MDU_OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, "div 7/-2");
      issue(MDU_OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, "divu 100/7");
      issue(MDU_OP_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 33, "divu by 0");
      issue(MDU_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33, "div overflow");
      issue(MDU_OP_MTHI,  32'hDEADBEEF, 32'd0,        32'hDEADBEEF, curLo,        0,  "mthi");
      issue(MDU_OP_MTLO,  32'hCAFEF00D, 32'd0,        curHi,        32'hCAFEF00D, 0,  "mtlo");
      @(negedge clk);
      MDUOpE = MDU_OP_MTLO;
      SrcAE = 32'h11111111;
      ExceptDealM = 1'b1;
      @(negedge clk);
      MDUOpE = MDU_OP_NONE;
      ExceptDealM = 1'b0;
      #1;
      check("mtlo flushed LO", LOOut, curLo);
      check("mtlo flushed HI", HIOut, curHi);
      @(negedge clk);
      prevHi = curHi;
      prevLo = curLo;
      MDUOpE = MDU_OP_DIVU;
      SrcAE = 32'd1000;
      SrcBE = 32'd33;
      sb.push_back({32'd10, 32'd30});
      curHi = 32'd10;
      curLo = 32'd30;
      waitReady();
      check("stall div busy cycles", 32'(low), 32'd33);
      MemStall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         check("stall ready", 32'(MDUReadyE), 32'd1);
         check("stall HI hold", HIOut, prevHi);
         check("stall LO hold", LOOut, prevLo);
      end
      MemStall = 1'b0;
      @(posedge clk);
      @(negedge clk);
      MDUOpE = MDU_OP_NONE;
      repeat (3) @(negedge clk);
      #1;
      check("no restart ready", 32'(MDUReadyE), 32'd1);
      check("single commit HI", HIOut, curHi);
      check("single commit LO", LOOut, curLo);
      @(negedge clk);
      MDUOpE = MDU_OP_DIVU;
      SrcAE = 32'd5;
      SrcBE = 32'd1;
      repeat (10) @(negedge clk);
      ExceptDealM = 1'b1;
      MDUOpE = MDU_OP_NONE;
      @(negedge clk);
      ExceptDealM = 1'b0;
      #1;
      check("abort ready", 32'(MDUReadyE), 32'd1);
      repeat (40) @(negedge clk);
      #1;
      check("abort HI hold", HIOut, curHi);
      check("abort LO hold", LOOut, curLo);
      @(negedge clk);
      MDUOpE = MDU_OP_MULT;
      SrcAE = 32'd3;
      SrcBE = 32'd5;
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      MDUOpE = MDU_OP_NONE;
      #1;
      check("mid reset ready", 32'(MDUReadyE), 32'd1);
      @(negedge clk);
      #1;
      check("mid reset HI", HIOut, 32'd0);
      check("mid reset LO", LOOut, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      #1;
      check("post reset ready", 32'(MDUReadyE), 32'd1);
      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
